diamond_collision: RTL and testbench

//  Consumer side of the diamond pixel interface. Watches the per-pixel diamond

---
 rtl/diamond_collision.sv | 164 ++++++++++++++++
 tb/tb_diamond_collision.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diamond_collision.sv
// Per-frame diamond/head overlap detector: eat pulse, saturating score and relocate req/ack handshake.
// Build option SCORE_BCD_EN: score held as packed BCD (SCORE_W/4 digits) instead of plain binary.
module diamond_collision #(
    parameter int SCORE_W     = 8,
    parameter int MAX_SCORE   = 99,
    parameter int HIT_MIN_PIX = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               game_over,
    input  logic               snake_alive,
    input  logic               video_on,
    input  logic               frame_end,
    input  logic               diamond_pix,
    input  logic               head_pix,
    input  logic               relocate_ack,
    output logic               relocate_req,
    output logic               eat_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               reloc_err
);
    localparam int OVL_W  = $clog2(HIT_MIN_PIX + 1);
    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [OVL_W-1:0]  HIT_MIN  = OVL_W'(HIT_MIN_PIX);
    localparam logic [WAIT_W-1:0] ACK_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] SCAN = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

`ifdef SCORE_BCD_EN
    function automatic logic [SCORE_W-1:0] to_bcd(input int v);
        logic [SCORE_W-1:0] r;
        int                 t;
        r = '0;
        t = v;
        for (int i = 0; i < SCORE_W / 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [SCORE_W-1:0] MAX_CODE = to_bcd(MAX_SCORE);

    // Decimal ripple increment; valid BCD compares correctly as binary for the ceiling test.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = s;
        carry = (s < MAX_CODE);
        for (int i = 0; i < SCORE_W / 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction
`else
    localparam logic [SCORE_W-1:0] MAX_CODE = SCORE_W'(MAX_SCORE);

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s < MAX_CODE) ? s + SCORE_W'(1) : s;
    endfunction
`endif

    logic [1:0]         state_q, state_d;
    logic [OVL_W-1:0]   ovl_q, ovl_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               req_q, req_d;
    logic               eat_q, eat_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               err_q, err_d;
    logic               hit;

    // A pixel coinciding with frame_end belongs to no frame and is never counted.
    assign hit = video_on & diamond_pix & head_pix & ~frame_end;

    always_comb begin
        state_d = state_q;
        ovl_d   = ovl_q;
        wait_d  = wait_q;
        req_d   = req_q;
        eat_d   = 1'b0;
        score_d = score_q;
        err_d   = err_q;
        if (game_over) begin
            state_d = SCAN;
            ovl_d   = '0;
            wait_d  = '0;
            req_d   = 1'b0;
        end else begin
            if (frame_end) begin
                ovl_d = '0;
            end
            case (state_q)
                SCAN: begin
                    if (frame_end) begin
                        if (snake_alive && (ovl_q == HIT_MIN)) begin
                            eat_d   = 1'b1;
                            score_d = score_inc(score_q);
                            req_d   = 1'b1;
                            wait_d  = '0;
                            state_d = REQ;
                        end
                    end else if (hit && (ovl_q != HIT_MIN)) begin
                        ovl_d = ovl_q + OVL_W'(1);
                    end
                end
                REQ: begin
                    if (relocate_ack) begin
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end else if (wait_q == ACK_LAST) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                // One whole frame is skipped so the diamond has moved before detection resumes.
                HOLD: begin
                    if (frame_end) begin
                        state_d = SCAN;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= SCAN;
            ovl_q   <= '0;
            wait_q  <= '0;
            req_q   <= 1'b0;
            eat_q   <= 1'b0;
            score_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovl_q   <= ovl_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            eat_q   <= eat_d;
            score_q <= score_d;
            err_q   <= err_d;
        end
    end

    assign relocate_req = req_q;
    assign eat_pulse    = eat_q;
    assign score        = score_q;
    assign reloc_err    = err_q;
endmodule

// File: tb/tb_diamond_collision.sv
// Bench for diamond_collision: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_diamond_collision;
    localparam int SCORE_W     = 8;
    localparam int MAX_SCORE   = 99;
    localparam int HIT_MIN_PIX = 4;
    localparam int ACK_TIMEOUT = 255;

    logic               vga_clk = 1'b0;
    logic               reset = 1'b1;
    logic               game_over = 1'b0;
    logic               snake_alive = 1'b1;
    logic               video_on = 1'b0;
    logic               frame_end = 1'b0;
    logic               diamond_pix = 1'b0;
    logic               head_pix = 1'b0;
    logic               relocate_ack = 1'b0;
    logic               relocate_req;
    logic               eat_pulse;
    logic [SCORE_W-1:0] score;
    logic               reloc_err;

    int n_checks = 0;
    int n_fail   = 0;
    int m_score  = 0;

    always #5 vga_clk = ~vga_clk;

    diamond_collision #(
        .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE),
        .HIT_MIN_PIX(HIT_MIN_PIX), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .game_over(game_over),
        .snake_alive(snake_alive), .video_on(video_on), .frame_end(frame_end),
        .diamond_pix(diamond_pix), .head_pix(head_pix), .relocate_ack(relocate_ack),
        .relocate_req(relocate_req), .eat_pulse(eat_pulse), .score(score),
        .reloc_err(reloc_err)
    );

    // Expected score code for a given number of eats.
    function automatic logic [SCORE_W-1:0] exp_score(input int n);
        int                 v;
        logic [SCORE_W-1:0] r;
        v = (n > MAX_SCORE) ? MAX_SCORE : n;
`ifdef SCORE_BCD_EN
        r = '0;
        for (int i = 0; i < SCORE_W / 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
`else
        r = SCORE_W'(v);
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // n overlapping pixels, each followed by a non-overlap pixel and a blanked overlap.
    task automatic drive_frame(input int n);
        for (int i = 0; i < n; i++) begin
            video_on = 1'b1; diamond_pix = 1'b1; head_pix = 1'b1; tick();
            video_on = 1'b1; diamond_pix = 1'b1; head_pix = 1'b0; tick();
            video_on = 1'b0; diamond_pix = 1'b1; head_pix = 1'b1; tick();
        end
        video_on = 1'b0; diamond_pix = 1'b0; head_pix = 1'b0; tick();
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic ack_pulse();
        relocate_ack = 1'b1;
        tick();
        relocate_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (relocate_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", relocate_req); end
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_eat: got %b want 0", eat_pulse); end
        n_checks++; if (score !== '0) begin n_fail++; $display("FAIL reset_score: got %h want 0", score); end
        n_checks++; if (reloc_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", reloc_err); end
        reset = 1'b0;
        m_score = 0;
        tick();
    endtask

    task automatic test_eat_basic();
        drive_frame(4);
        end_frame();
        m_score++;
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL basic_eat: got %b want 1", eat_pulse); end
        n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL basic_score: got %h want %h", score, exp_score(m_score)); end
        n_checks++; if (relocate_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_rise: got %b want 1", relocate_req); end
        tick();
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL basic_eat_width: got %b want 0", eat_pulse); end
        repeat (5) tick();
        n_checks++; if (relocate_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_hold: got %b want 1", relocate_req); end
        ack_pulse();
        n_checks++; if (relocate_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %b want 0", relocate_req); end
        end_frame();
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL basic_hold_eat: got %b want 0", eat_pulse); end
    endtask

    task automatic test_boundaries();
        drive_frame(3);
        end_frame();
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL short_eat: got %b want 0", eat_pulse); end
        n_checks++; if (relocate_req !== 1'b0) begin n_fail++; $display("FAIL short_req: got %b want 0", relocate_req); end
        n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL short_score: got %h want %h", score, exp_score(m_score)); end
        // fourth overlap lands on the frame_end cycle
        drive_frame(3);
        video_on = 1'b1; diamond_pix = 1'b1; head_pix = 1'b1;
        end_frame();
        video_on = 1'b0; diamond_pix = 1'b0; head_pix = 1'b0;
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL fe_pixel_eat: got %b want 0", eat_pulse); end
        drive_frame(4);
        snake_alive = 1'b0;
        end_frame();
        snake_alive = 1'b1;
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL dead_eat: got %b want 0", eat_pulse); end
        drive_frame(3);
        end_frame();
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL dead_cleared: got %b want 0", eat_pulse); end
        ack_pulse();
        n_checks++; if (relocate_req !== 1'b0 || reloc_err !== 1'b0) begin n_fail++; $display("FAIL scan_ack: req=%b err=%b want 0 0", relocate_req, reloc_err); end
        drive_frame(9);
        end_frame();
        m_score++;
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL ovl_sat_eat: got %b want 1", eat_pulse); end
        ack_pulse();
        end_frame();
    endtask

    task automatic test_timeout();
        int low_cycles;
        drive_frame(4);
        end_frame();
        m_score++;
        n_checks++; if (relocate_req !== 1'b1) begin n_fail++; $display("FAIL to_req_rise: got %b want 1", relocate_req); end
        low_cycles = 0;
        repeat (ACK_TIMEOUT - 1) begin
            tick();
            if (relocate_req !== 1'b1) low_cycles++;
        end
        n_checks++; if (low_cycles != 0) begin n_fail++; $display("FAIL to_req_window: %0d early-low cycles, want 0", low_cycles); end
        n_checks++; if (reloc_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b want 0", reloc_err); end
        tick();
        n_checks++; if (relocate_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b want 0", relocate_req); end
        n_checks++; if (reloc_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", reloc_err); end
        drive_frame(4);
        ack_pulse();
        end_frame();
        n_checks++; if (eat_pulse !== 1'b0 || relocate_req !== 1'b0) begin n_fail++; $display("FAIL to_hold: eat=%b req=%b want 0 0", eat_pulse, relocate_req); end
        drive_frame(4);
        end_frame();
        m_score++;
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL to_rescan_eat: got %b want 1", eat_pulse); end
        ack_pulse();
        end_frame();
        n_checks++; if (reloc_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", reloc_err); end
    endtask

    task automatic test_hold_frame();
        drive_frame(4);
        end_frame();
        m_score++;
        ack_pulse();
        drive_frame(5);
        end_frame();
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL hold_eat: got %b want 0", eat_pulse); end
        n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL hold_score: got %h want %h", score, exp_score(m_score)); end
        drive_frame(5);
        end_frame();
        m_score++;
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL hold_next_eat: got %b want 1", eat_pulse); end
        n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL hold_next_score: got %h want %h", score, exp_score(m_score)); end
        ack_pulse();
        end_frame();
    endtask

    task automatic test_game_over();
        drive_frame(4);
        end_frame();
        m_score++;
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        n_checks++; if (relocate_req !== 1'b0) begin n_fail++; $display("FAIL go_req: got %b want 0", relocate_req); end
        n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL go_score: got %h want %h", score, exp_score(m_score)); end
        n_checks++; if (reloc_err !== 1'b1) begin n_fail++; $display("FAIL go_err_held: got %b want 1", reloc_err); end
        drive_frame(4);
        end_frame();
        m_score++;
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL go_scan_eat: got %b want 1", eat_pulse); end
        ack_pulse();
        end_frame();
        drive_frame(4);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        end_frame();
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL go_ovl_clear: got %b want 0", eat_pulse); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_score = 0;
        n_checks++; if (score !== '0 || reloc_err !== 1'b0) begin n_fail++; $display("FAIL go_reset: score=%h err=%b want 0 0", score, reloc_err); end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= MAX_SCORE + 2; k++) begin
            drive_frame(4);
            end_frame();
            m_score++;
            n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_eat_%0d: got %b want 1", k, eat_pulse); end
            n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL sat_score_%0d: got %h want %h", k, score, exp_score(m_score)); end
            ack_pulse();
            end_frame();
        end
    endtask

    task automatic test_random();
        bit scan;
        bit alive;
        bit exp_eat;
        int cnt;
        int npix;
        bit vo, d, h;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_score = 0;
        scan = 1'b1;
        for (int f = 0; f < 60; f++) begin
            cnt  = 0;
            npix = $urandom_range(4, 16);
            for (int p = 0; p < npix; p++) begin
                vo = ($urandom % 4) != 0;
                d  = ($urandom % 3) != 0;
                h  = ($urandom % 3) != 0;
                video_on = vo; diamond_pix = d; head_pix = h;
                if (vo && d && h) cnt++;
                tick();
            end
            alive = ($urandom % 8) != 0;
            snake_alive = alive;
            video_on = $urandom % 2; diamond_pix = $urandom % 2; head_pix = $urandom % 2;
            end_frame();
            video_on = 1'b0; diamond_pix = 1'b0; head_pix = 1'b0;
            snake_alive = 1'b1;
            exp_eat = scan && alive && (cnt >= HIT_MIN_PIX);
            if (exp_eat) m_score++;
            n_checks++; if (eat_pulse !== exp_eat) begin n_fail++; $display("FAIL rnd_eat_f%0d: got %b want %b", f, eat_pulse, exp_eat); end
            n_checks++; if (score !== exp_score(m_score)) begin n_fail++; $display("FAIL rnd_score_f%0d: got %h want %h", f, score, exp_score(m_score)); end
            n_checks++; if (relocate_req !== exp_eat) begin n_fail++; $display("FAIL rnd_req_f%0d: got %b want %b", f, relocate_req, exp_eat); end
            tick();
            n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL rnd_eat_width_f%0d: got %b want 0", f, eat_pulse); end
            if (exp_eat) begin
                repeat ($urandom_range(0, 5)) tick();
                n_checks++; if (relocate_req !== 1'b1) begin n_fail++; $display("FAIL rnd_req_wait_f%0d: got %b want 1", f, relocate_req); end
                ack_pulse();
                n_checks++; if (relocate_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_ack_f%0d: got %b want 0", f, relocate_req); end
                scan = 1'b0;
            end else begin
                scan = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_eat_basic();
        test_boundaries();
        test_timeout();
        test_hold_frame();
        test_game_over();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
